// File: rtl/muldiv_ctrl.sv
// Multicycle mult/div sequencer owning the HI/LO pair (radix-2 Booth / restoring divide, 34-cycle op).
// Define MULDIV_UNSIGNED_EN to add the unsgn port for multu/divu.
module muldiv_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mult,
   input  logic             div,
`ifdef MULDIV_UNSIGNED_EN
   input  logic             unsgn,
`endif
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             hi_we,
   input  logic             lo_we,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             divzero
);

   typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, WB} state_t;

   state_t           state_q, state_d;
   logic [WIDTH:0]   acc_q, acc_d;     // Booth accumulator / partial remainder
   logic [WIDTH-1:0] q_q, q_d;         // multiplier / dividend-quotient shift register
   logic [WIDTH-1:0] m_q, m_d;         // multiplicand / divisor
   logic             qm1_q, qm1_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             uns_q, uns_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             done_q, done_d, dz_q, dz_d;
   logic             uns_in;

`ifdef MULDIV_UNSIGNED_EN
   assign uns_in = unsgn;
`else
   assign uns_in = 1'b0;
`endif

   // Multiply step: Booth recoding when signed, plain shift-add when unsigned.
   logic [WIDTH:0] m_ext, mul_sum;
   logic           mul_fill;

   assign m_ext = {m_q[WIDTH-1] & ~uns_q, m_q};

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      mul_sum = acc_q;
      if (uns_q) begin
         if (q_q[0]) mul_sum = acc_q + m_ext;
      end else begin
         case ({q_q[0], qm1_q})
            2'b01:   mul_sum = acc_q + m_ext;
            2'b10:   mul_sum = acc_q - m_ext;
            default: mul_sum = acc_q;
         endcase
      end
   end

   assign mul_fill = uns_q ? 1'b0 : mul_sum[WIDTH];

   // Restoring divide step on magnitudes.
   logic [WIDTH:0] div_shift, div_rem;
   logic           div_ge;

   assign div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, m_q};
   assign div_rem   = div_ge ? (div_shift - {1'b0, m_q}) : div_shift;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      q_d      = q_q;
      m_d      = m_q;
      qm1_d    = qm1_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      uns_d    = uns_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dz_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (mult) begin
               state_d  = MUL_RUN;
               acc_d    = '0;
               q_d      = b_in;
               m_d      = a_in;
               qm1_d    = 1'b0;
               cnt_d    = '0;
               is_div_d = 1'b0;
               uns_d    = uns_in;
            end else if (div) begin
               if (b_in == '0) begin
                  dz_d = 1'b1;
               end else begin
                  state_d  = DIV_RUN;
                  acc_d    = '0;
                  cnt_d    = '0;
                  is_div_d = 1'b1;
                  uns_d    = uns_in;
                  if (uns_in) begin
                     q_d    = a_in;
                     m_d    = b_in;
                     qneg_d = 1'b0;
                     rneg_d = 1'b0;
                  end else begin
                     q_d    = a_in[WIDTH-1] ? ('0 - a_in) : a_in;
                     m_d    = b_in[WIDTH-1] ? ('0 - b_in) : b_in;
                     qneg_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
                     rneg_d = a_in[WIDTH-1];
                  end
               end
            end else begin
               if (hi_we) hi_d = a_in;
               if (lo_we) lo_d = a_in;
            end
         end
         MUL_RUN: begin
            acc_d = {mul_fill, mul_sum[WIDTH:1]};
            q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
            qm1_d = q_q[0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) state_d = WB;
         end
         DIV_RUN: begin
            acc_d = div_rem;
            q_d   = {q_q[WIDTH-2:0], div_ge};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) state_d = WB;
         end
         WB: begin
            state_d = IDLE;
            done_d  = 1'b1;
            cnt_d   = '0;
            if (is_div_q) begin
               lo_d = qneg_q ? ('0 - q_q) : q_q;
               hi_d = rneg_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
            end else begin
               hi_d = acc_q[WIDTH-1:0];
               lo_d = q_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; every register, datapath included, is reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         q_q      <= '0;
         m_q      <= '0;
         qm1_q    <= 1'b0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         uns_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         q_q      <= q_d;
         m_q      <= m_d;
         qm1_q    <= qm1_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         uns_q    <= uns_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
      end
   end

   assign hi      = hi_q;
   assign lo      = lo_q;
   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign divzero = dz_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed, table-driven bench for muldiv_ctrl plus hand-written multi-cycle corner sequences.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        mult, div, unsgn, hi_we, lo_we;
   logic [31:0] a_in, b_in;
   logic [31:0] hi, lo;
   logic        busy, done, divzero;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   muldiv_ctrl dut (
      .clk     (clk),
      .reset   (reset),
      .mult    (mult),
      .div     (div),
`ifdef MULDIV_UNSIGNED_EN
      .unsgn   (unsgn),
`endif
      .a_in    (a_in),
      .b_in    (b_in),
      .hi_we   (hi_we),
      .lo_we   (lo_we),
      .hi      (hi),
      .lo      (lo),
      .busy    (busy),
      .done    (done),
      .divzero (divzero)
   );

   typedef struct {
      logic        m;
      logic        d;
      logic        u;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      mult = 1'b0; div = 1'b0; unsgn = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge of the done cycle (or after the bound expires).
   task automatic run_op(input logic m, input logic d, input logic u,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic hwe, input logic lwe,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input string name);
      logic [31:0] prev_hi, prev_lo;
      int          busy_n;
      bit          seen_done, stable;
      busy_n = 0; seen_done = 0; stable = 1;
      mult = m; div = d; unsgn = u; a_in = a; b_in = b; hi_we = hwe; lo_we = lwe;
      prev_hi = hi; prev_lo = lo;
      @(negedge clk);
      clear_inputs();
      a_in = 32'h0BAD_F00D; b_in = 32'h0;
      for (int k = 0; k < 40 && !seen_done; k++) begin
         if (done) seen_done = 1;
         else begin
            if (busy) busy_n++;
            if (hi !== prev_hi || lo !== prev_lo) stable = 0;
            @(negedge clk);
         end
      end
      check({name, " done"}, 64'(seen_done), 64'd1);
      check({name, " busy cycles"}, 64'(busy_n), 64'd33);
      check({name, " hi/lo held mid-op"}, 64'(stable), 64'd1);
      check({name, " busy low at done"}, 64'(busy), 64'd0);
      check({name, " result"}, {hi, lo}, {exp_hi, exp_lo});
   endtask

   initial begin
      bit any_bad;
      clear_inputs();
      a_in = '0; b_in = '0;
      reset = 1'b0;

      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mul 7*-3"});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mul min*min"});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2"});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div min/-1"});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, "mul carry"});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mul -1*-1"});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'd100,       32'd7,        32'd2,        32'd14,        "div 100/7"});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'd7,         32'hFFFF_FFFE, 32'd1,       32'hFFFF_FFFD, "div 7/-2"});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,       "div -7/-2"});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, "mul max*max"});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 32'd3,         32'd5,        32'd3,        32'd0,         "div 3/5"});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 32'd0,         32'd5,        32'd0,        32'd0,         "mul 0*5"});
`ifdef MULDIV_UNSIGNED_EN
      vecs.push_back('{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2,        32'd1,        32'hFFFF_FFFE, "multu"});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2,        32'd1,        32'h7FFF_FFFF, "divu"});
      vecs.push_back('{1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu max"});
`endif

      repeat (2) @(negedge clk);
      check("reset outputs", {hi, lo, 29'd0, busy, done, divzero}, 96'd0);
      reset = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         run_op(vecs[i].m, vecs[i].d, vecs[i].u, vecs[i].a, vecs[i].b, 1'b0, 1'b0,
                vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].name);
         @(negedge clk);
         check({vecs[i].name, " done one cycle"}, {63'd0, done}, 64'd0);
      end

      // Back-to-back: second request is presented in the done cycle and accepted on the next edge.
      run_op(1'b1, 1'b0, 1'b0, 32'd9, 32'd9, 1'b0, 1'b0, 32'd0, 32'd81, "b2b first");
      run_op(1'b0, 1'b1, 1'b0, 32'd81, 32'd4, 1'b0, 1'b0, 32'd1, 32'd20, "b2b second");
      @(negedge clk);

      // mult+div together: mult wins; same-cycle hi_we/lo_we are dropped.
      run_op(1'b1, 1'b1, 1'b0, 32'd6, 32'd2, 1'b1, 1'b1, 32'd0, 32'd12, "mult wins");
      @(negedge clk);

      // mthi / mtlo writes.
      hi_we = 1'b1; a_in = 32'h0000_1234;
      @(negedge clk);
      hi_we = 1'b0;
      check("mthi", {hi, lo}, {32'h0000_1234, 32'd12});
      lo_we = 1'b1; a_in = 32'h0000_ABCD;
      @(negedge clk);
      lo_we = 1'b0;
      check("mtlo", {hi, lo}, {32'h0000_1234, 32'h0000_ABCD});

      // Divide by zero: one-cycle divzero, never busy, no done, HI/LO untouched.
      div = 1'b1; a_in = 32'd5; b_in = 32'd0;
      @(negedge clk);
      clear_inputs();
      check("divzero pulse", {62'd0, divzero, busy}, {62'd0, 1'b1, 1'b0});
      check("divzero hi/lo", {hi, lo}, {32'h0000_1234, 32'h0000_ABCD});
      any_bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (divzero || busy || done) any_bad = 1;
      end
      check("divzero quiet after", 64'(any_bad), 64'd0);

      // Both write enables at once.
      hi_we = 1'b1; lo_we = 1'b1; a_in = 32'h5555_AAAA;
      @(negedge clk);
      clear_inputs();
      check("mthi+mtlo", {hi, lo}, {32'h5555_AAAA, 32'h5555_AAAA});

      // Requests while busy are ignored and the op completes normally.
      mult = 1'b1; a_in = 32'd3; b_in = 32'd4;
      @(negedge clk);
      clear_inputs();
      repeat (9) @(negedge clk);
      div = 1'b1; hi_we = 1'b1; lo_we = 1'b1; a_in = 32'hDEAD_BEEF; b_in = 32'd1;
      @(negedge clk);
      clear_inputs();
      check("busy-ignore hi/lo held", {hi, lo}, {32'h5555_AAAA, 32'h5555_AAAA});
      begin
         bit seen;
         seen = 0;
         for (int k = 0; k < 40 && !seen; k++) begin
            if (done) seen = 1;
            else @(negedge clk);
         end
         check("busy-ignore done", 64'(seen), 64'd1);
      end
      check("busy-ignore result", {hi, lo}, {32'd0, 32'd12});
      @(negedge clk);
      check("busy-ignore no extra op", {62'd0, busy, done}, 64'd0);

      // Reset mid-op: everything clears at once and the aborted op never reports done.
      hi_we = 1'b1; lo_we = 1'b1; a_in = 32'h0F0F_0F0F;
      @(negedge clk);
      clear_inputs();
      mult = 1'b1; a_in = 32'd3; b_in = 32'd4;
      @(negedge clk);
      clear_inputs();
      repeat (9) @(negedge clk);
      div = 1'b1; hi_we = 1'b1; a_in = 32'h0000_0999; b_in = 32'd1;
      @(negedge clk);
      clear_inputs();
      check("mid-op busy", {63'd0, busy}, 64'd1);
      repeat (9) @(negedge clk);
      #1 reset = 1'b0;
      #1;
      check("async reset mid-op", {hi, lo, 29'd0, busy, done, divzero}, 96'd0);
      @(negedge clk);
      reset = 1'b1;
      any_bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) any_bad = 1;
      end
      check("no done after reset", 64'(any_bad), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
